// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch stage and its environment: the instruction
// memory port, the redirect request from execute and the IF/ID slot towards
// decode.
//
// Handshake: the IF/ID slot is offered while if_valid is high. It is consumed
// on a rising edge where if_valid && id_ready are both high. While if_valid is
// high and id_ready is low, every if_* output is held stable. A redirect may
// withdraw if_valid without a transfer, because it flushes the slot.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_misaligned;

  // The fetch unit drives the memory address and the IF/ID slot.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
    output if_misaligned
  );

  // Memory, execute and decode sit on this side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_ready,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
    input  if_misaligned
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and drives the word address into instruction memory.
// It captures the returned word into a registered IF/ID slot, and takes redirects
// from execute. A misaligned redirect target produces a single trap entry, after
// which fetch is suspended until the next redirect arrives.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] plus4_q, plus4_d;
  logic        mis_q, mis_d;
  logic        adv;
  logic [31:0] pc_inc;

  assign adv    = !valid_q || bus.id_ready;
  assign pc_inc = pc_q + 32'd4;

  // State, PC and IF/ID slot registers; reset empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      ifpc_q  <= 32'h0;
      plus4_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      plus4_q <= plus4_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and slot update. A redirect beats advancing, and advancing beats holding.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    plus4_d = plus4_q;
    mis_d   = mis_q;
    if (bus.redirect_valid) begin
      // Flush the slot even under a decode stall; no word is captured this cycle.
      valid_d = 1'b0;
      mis_d   = 1'b0;
      pc_d    = bus.redirect_pc;
      state_d = (bus.redirect_pc[1:0] != 2'b00) ? ST_TRAP : ST_RUN;
    end else if (adv) begin
      case (state_q)
        ST_RUN: begin
          instr_d = bus.imem_rdata;
          ifpc_d  = pc_q;
          plus4_d = pc_inc;
          mis_d   = 1'b0;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end
        ST_TRAP: begin
          // Issue the trap entry once; the PC keeps the offending target.
          instr_d = NOP;
          ifpc_d  = pc_q;
          plus4_d = pc_inc;
          mis_d   = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HALT;
        end
        ST_HALT: begin
          valid_d = 1'b0;
          mis_d   = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign bus.imem_addr     = {2'b00, pc_q[31:2]};
  assign bus.if_valid      = valid_q;
  assign bus.if_instr      = instr_q;
  assign bus.if_pc         = ifpc_q;
  assign bus.if_pc_plus4   = plus4_q;
  assign bus.if_misaligned = mis_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. It runs directed scenarios taken from the
// fetch-stage behaviour. It also runs a randomized stall/redirect run that is
// checked against a small program-order model with an expected-instruction
// queue.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state_dbg;
  logic [31:0] mem [0:255];
  logic [31:0] words [0:4];
  logic [31:0] acc_q [$];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  instr_fetch_unit_if bus();

  // Combinational instruction memory (256 words, address wraps on the low byte).
  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Log every instruction decode accepts.
  always @(posedge clk) begin
    if (!rst && bus.if_valid && bus.id_ready) acc_q.push_back(bus.if_instr);
  end

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %h want 0", bus.if_valid); end
    n_checks++; if (bus.if_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", bus.if_instr, NOP); end
    n_checks++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.if_pc); end
    n_checks++; if (bus.if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_plus4: got %h want 0", bus.if_pc_plus4); end
    n_checks++; if (bus.if_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %h want 0", bus.if_misaligned); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.imem_addr !== 32'(k)) begin n_fail++; $display("FAIL stream_addr: got %h want %h", bus.imem_addr, 32'(k)); end
      tick();
      n_checks++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: got %h want 1", bus.if_valid); end
      n_checks++; if (bus.if_instr !== words[k]) begin n_fail++; $display("FAIL stream_instr: got %h want %h", bus.if_instr, words[k]); end
      n_checks++; if (bus.if_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc: got %h want %h", bus.if_pc, 32'(4 * k)); end
      n_checks++; if (bus.if_pc_plus4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL stream_plus4: got %h want %h", bus.if_pc_plus4, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    bus.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus.if_instr !== words[1]) begin n_fail++; $display("FAIL stall_instr: got %h want %h", bus.if_instr, words[1]); end
      n_checks++; if (bus.if_pc !== 32'h4 || bus.if_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL stall_pc: got %h/%h want 4/8", bus.if_pc, bus.if_pc_plus4); end
      n_checks++; if (bus.if_valid !== 1'b1 || bus.if_misaligned !== 1'b0) begin n_fail++; $display("FAIL stall_flags: got %b%b want 10", bus.if_valid, bus.if_misaligned); end
      n_checks++; if (bus.imem_addr !== 32'h2) begin n_fail++; $display("FAIL stall_addr: got %h want 2", bus.imem_addr); end
    end
    acc_q.delete();
    bus.id_ready = 1'b1;
    tick();
    n_checks++; if (bus.if_instr !== words[2] || bus.if_pc !== 32'h8) begin n_fail++; $display("FAIL stall_release: got %h@%h want %h@8", bus.if_instr, bus.if_pc, words[2]); end
    n_checks++; if (acc_q.size() != 1 || acc_q[0] !== words[1]) begin n_fail++; $display("FAIL stall_accept: got %0d accepts want 1 of %h", acc_q.size(), words[1]); end
  endtask

  task automatic test_redirect_stall();
    acc_q.delete();
    bus.id_ready = 1'b0;
    redirect_to(32'h10);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rstall_flush: got %h want 0", bus.if_valid); end
    n_checks++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL rstall_addr: got %h want 4", bus.imem_addr); end
    tick();
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10) begin n_fail++; $display("FAIL rstall_pc: got %h@%h want 1@10", bus.if_valid, bus.if_pc); end
    n_checks++; if (bus.if_instr !== 32'h0010_0193) begin n_fail++; $display("FAIL rstall_instr: got %h want 00100193", bus.if_instr); end
    n_checks++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL rstall_accept: got %0d accepts want 0", acc_q.size()); end
  endtask

  task automatic test_misaligned();
    bus.id_ready = 1'b1;
    redirect_to(32'h6);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush: got %h want 0", bus.if_valid); end
    tick();
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_entry: got %b%b want 11", bus.if_valid, bus.if_misaligned); end
    n_checks++; if (bus.if_instr !== NOP) begin n_fail++; $display("FAIL mis_instr: got %h want %h", bus.if_instr, NOP); end
    n_checks++; if (bus.if_pc !== 32'h6 || bus.if_pc_plus4 !== 32'hA) begin n_fail++; $display("FAIL mis_pc: got %h/%h want 6/a", bus.if_pc, bus.if_pc_plus4); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.if_valid !== 1'b0 || bus.if_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_halt: got %b%b want 00", bus.if_valid, bus.if_misaligned); end
    end
    redirect_to(32'h0);
    tick();
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== words[0]) begin n_fail++; $display("FAIL mis_resume: got %h %h@%h want 1 %h@0", bus.if_valid, bus.if_instr, bus.if_pc, words[0]); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC);
    n_checks++; if (bus.imem_addr !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h want 3fffffff", bus.imem_addr); end
    tick();
    n_checks++; if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h/%h want fffffffc/0", bus.if_pc, bus.if_pc_plus4); end
    n_checks++; if (bus.if_instr !== mem[255]) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", bus.if_instr, mem[255]); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    logic [129:0] rst_img;
    rst_img = {1'b0, 1'b0, NOP, 32'h0, 32'h0, 32'h0};
    redirect_to(32'h22);
    rst = 1'b1;
    tick();
    n_checks++; if ({bus.if_valid, bus.if_misaligned, bus.if_instr, bus.if_pc, bus.if_pc_plus4, bus.imem_addr} !== rst_img) begin n_fail++; $display("FAIL rmid_trap: got %h want %h", {bus.if_valid, bus.if_misaligned, bus.if_instr, bus.if_pc, bus.if_pc_plus4, bus.imem_addr}, rst_img); end
    rst = 1'b0;
    redirect_to(32'h8);
    tick();
    bus.id_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if ({bus.if_valid, bus.if_misaligned, bus.if_instr, bus.if_pc, bus.if_pc_plus4, bus.imem_addr} !== rst_img) begin n_fail++; $display("FAIL rmid_stall: got %h want %h", {bus.if_valid, bus.if_misaligned, bus.if_instr, bus.if_pc, bus.if_pc_plus4, bus.imem_addr}, rst_img); end
    rst = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== words[0]) begin n_fail++; $display("FAIL rmid_restart: got %h %h@%h want 1 %h@0", bus.if_valid, bus.if_instr, bus.if_pc, words[0]); end
  endtask

  // Random decode stalls and aligned redirects. The model tracks only the
  // program-order next address and the one outstanding slot entry.
  task automatic test_back_to_back_random();
    logic        m_valid;
    logic [31:0] m_slot_pc, m_next, tgt;
    logic        rdy, redir;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_valid = 1'b0;
    m_slot_pc = 32'h0;
    m_next = 32'h0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      tgt   = 32'($urandom_range(0, 255)) << 2;
      bus.id_ready       = rdy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      n_checks++; if (bus.if_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %h want %h", cyc, bus.if_valid, m_valid); end
      n_checks++; if (bus.imem_addr !== {2'b00, m_next[31:2]}) begin n_fail++; $display("FAIL rnd_addr: cycle %0d got %h want %h", cyc, bus.imem_addr, {2'b00, m_next[31:2]}); end
      if (m_valid) begin
        n_checks++; if (bus.if_pc !== m_slot_pc) begin n_fail++; $display("FAIL rnd_pc: cycle %0d got %h want %h", cyc, bus.if_pc, m_slot_pc); end
      end
      if (bus.if_valid && rdy && !redir) begin
        n_checks++; if (exp_q.size() == 0 || bus.if_instr !== exp_q[0]) begin n_fail++; $display("FAIL rnd_accept: cycle %0d got %h want %h", cyc, bus.if_instr, (exp_q.size() != 0) ? exp_q[0] : 32'hx); end
      end
      if (redir) begin
        exp_q.delete();
        m_valid = 1'b0;
        m_next  = tgt;
      end else if (!m_valid || rdy) begin
        if (m_valid && exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(mem[m_next[9:2]]);
        m_slot_pc = m_next;
        m_valid   = 1'b1;
        m_next    = m_next + 32'd4;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    words[0] = 32'hFFC4_A303;
    words[1] = 32'h0064_A423;
    words[2] = 32'h0062_E233;
    words[3] = 32'hFE42_0AE3;
    words[4] = 32'h0010_0193;
    for (int i = 0; i < 5; i++) mem[i] = words[i];
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
